// File: rtl/mem_access_stage.sv
// Memory stage after EX: one data-memory req/ack transaction per instruction, stalls EX while waiting.
// Optional DMEM_TIMEOUT_EN adds an ACCESS watchdog that drops the request and raises sticky mem_err.
module mem_access_stage #(
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   input  logic              ALU_done,
   input  logic              flush,
   input  logic              RegWrite_in,
   input  logic              MemWrite_in,
   input  logic              MemRead_in,
   input  logic              MemToReg_in,
   input  logic              MemSrc_in,
   input  logic              call_in,
   input  logic              pop_in,
   input  logic              ret_in,
   input  logic [4:0]        DestReg_in,
   input  logic [DATA_W-1:0] ALU_addr,
   input  logic [DATA_W-1:0] NON_ALU_addr,
   input  logic [DATA_W-1:0] MemWrite_data_in,
   output logic              stall_out,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              wb_valid,
   output logic              RegWrite_out,
   output logic [4:0]        DestReg_out,
   output logic [DATA_W-1:0] WB_data,
   output logic              ret_valid,
   output logic [DATA_W-1:0] ret_pc,
   output logic              mem_err
);

   typedef enum logic [1:0] {IDLE, PASS, ACCESS} state_t;

   state_t            state_q, state_d;
   logic              we_q, we_d, m2r_q, m2r_d, rw_q, rw_d, ret_q, ret_d, flushed_q, flushed_d;
   logic [4:0]        dest_q, dest_d;
   logic [DATA_W-1:0] alu_q, alu_d, addr_q, addr_d, wdata_q, wdata_d;
   logic              wbv_q, wbv_d, rwo_q, rwo_d, retv_q, retv_d;
   logic [4:0]        desto_q, desto_d;
   logic [DATA_W-1:0] wbd_q, wbd_d, retpc_q, retpc_d;
   logic              accept;

`ifdef DMEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
`endif

   // call_in/pop_in only qualify the access; address, data and writeback select already encode them.
   logic unused_ok;
   assign unused_ok = call_in ^ pop_in;

   assign accept = (state_q == IDLE) && valid_in && ALU_done && !flush;

   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      m2r_d     = m2r_q;
      rw_d      = rw_q;
      ret_d     = ret_q;
      flushed_d = flushed_q;
      dest_d    = dest_q;
      alu_d     = alu_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wbv_d     = 1'b0;
      rwo_d     = 1'b0;
      retv_d    = 1'b0;
      desto_d   = desto_q;
      wbd_d     = wbd_q;
      retpc_d   = retpc_q;
`ifdef DMEM_TIMEOUT_EN
      cnt_d     = cnt_q;
      err_d     = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d   = (MemRead_in || MemWrite_in) ? ACCESS : PASS;
               we_d      = MemWrite_in;
               // A write wins over a read, so read data never reaches WB for it.
               m2r_d     = MemToReg_in && !MemWrite_in;
               rw_d      = RegWrite_in && !ret_in;
               ret_d     = ret_in;
               flushed_d = 1'b0;
               dest_d    = DestReg_in;
               alu_d     = ALU_addr;
               addr_d    = MemSrc_in ? NON_ALU_addr : ALU_addr;
               wdata_d   = MemWrite_data_in;
`ifdef DMEM_TIMEOUT_EN
               cnt_d     = '0;
`endif
            end
         end
         PASS: begin
            state_d = IDLE;
            if (!flush) begin
               wbv_d   = 1'b1;
               rwo_d   = rw_q;
               desto_d = dest_q;
               wbd_d   = alu_q;
            end
         end
         ACCESS: begin
            if (flush) flushed_d = 1'b1;
            if (dmem_ack) begin
               state_d = IDLE;
               // A squashed access still completes on the bus but leaves no architectural trace.
               if (!(flushed_q || flush)) begin
                  wbv_d   = 1'b1;
                  rwo_d   = rw_q;
                  desto_d = dest_q;
                  wbd_d   = m2r_q ? dmem_rdata : alu_q;
                  if (ret_q) begin
                     retv_d  = 1'b1;
                     retpc_d = dmem_rdata;
                  end
               end
            end
`ifdef DMEM_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         we_q      <= 1'b0;
         m2r_q     <= 1'b0;
         rw_q      <= 1'b0;
         ret_q     <= 1'b0;
         flushed_q <= 1'b0;
         dest_q    <= '0;
         alu_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wbv_q     <= 1'b0;
         rwo_q     <= 1'b0;
         retv_q    <= 1'b0;
         desto_q   <= '0;
         wbd_q     <= '0;
         retpc_q   <= '0;
`ifdef DMEM_TIMEOUT_EN
         cnt_q     <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         we_q      <= we_d;
         m2r_q     <= m2r_d;
         rw_q      <= rw_d;
         ret_q     <= ret_d;
         flushed_q <= flushed_d;
         dest_q    <= dest_d;
         alu_q     <= alu_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wbv_q     <= wbv_d;
         rwo_q     <= rwo_d;
         retv_q    <= retv_d;
         desto_q   <= desto_d;
         wbd_q     <= wbd_d;
         retpc_q   <= retpc_d;
`ifdef DMEM_TIMEOUT_EN
         cnt_q     <= cnt_d;
         err_q     <= err_d;
`endif
      end
   end

   // EX is also held while PASS drains, since only IDLE can take a new instruction.
   assign stall_out    = !rst && ((state_q == ACCESS) ||
                                  (valid_in && ((state_q == PASS) || !ALU_done)));
   assign dmem_req     = (state_q == ACCESS);
   assign dmem_we      = (state_q == ACCESS) && we_q;
   assign dmem_addr    = addr_q;
   assign dmem_wdata   = wdata_q;
   assign wb_valid     = wbv_q;
   assign RegWrite_out = rwo_q;
   assign DestReg_out  = desto_q;
   assign WB_data      = wbd_q;
   assign ret_valid    = retv_q;
   assign ret_pc       = retpc_q;
`ifdef DMEM_TIMEOUT_EN
   assign mem_err      = err_q;
`else
   assign mem_err      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: scoreboard of expected writebacks/returns checked against WB pulses.
module tb_mem_access_stage;
   logic        clk = 1'b0;
   logic        rst, valid_in, ALU_done, flush;
   logic        RegWrite_in, MemWrite_in, MemRead_in, MemToReg_in, MemSrc_in;
   logic        call_in, pop_in, ret_in;
   logic [4:0]  DestReg_in;
   logic [31:0] ALU_addr, NON_ALU_addr, MemWrite_data_in;
   logic        stall_out, dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        wb_valid, RegWrite_out, ret_valid, mem_err;
   logic [4:0]  DestReg_out;
   logic [31:0] WB_data, ret_pc;

   typedef struct {
      logic        rw;
      logic [4:0]  dest;
      logic [31:0] data;
   } wb_exp_t;

   wb_exp_t     wb_q[$];
   logic [31:0] ret_q[$];
   int          checks = 0, errors = 0, wb_seen = 0, wb_pushed = 0;

   always #5 clk = ~clk;

   mem_access_stage #(.DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .ALU_done(ALU_done), .flush(flush),
      .RegWrite_in(RegWrite_in), .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
      .MemToReg_in(MemToReg_in), .MemSrc_in(MemSrc_in), .call_in(call_in), .pop_in(pop_in),
      .ret_in(ret_in), .DestReg_in(DestReg_in), .ALU_addr(ALU_addr), .NON_ALU_addr(NON_ALU_addr),
      .MemWrite_data_in(MemWrite_data_in), .stall_out(stall_out), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .RegWrite_out(RegWrite_out),
      .DestReg_out(DestReg_out), .WB_data(WB_data), .ret_valid(ret_valid), .ret_pc(ret_pc),
      .mem_err(mem_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (wb_valid) begin
         wb_seen++;
         if (wb_q.size() == 0) chk("wb_unexpected", 1, 0);
         else begin
            wb_exp_t e;
            e = wb_q.pop_front();
            chk("wb_regwrite", RegWrite_out, e.rw);
            chk("wb_dest", DestReg_out, e.dest);
            chk("wb_data", WB_data, e.data);
         end
      end
      if (ret_valid) begin
         if (ret_q.size() == 0) chk("ret_unexpected", 1, 0);
         else chk("ret_pc", ret_pc, ret_q.pop_front());
         chk("ret_regwrite", RegWrite_out, 0);
      end
   end

   task automatic clear_ex();
      valid_in = 0; ALU_done = 0; RegWrite_in = 0; MemWrite_in = 0; MemRead_in = 0;
      MemToReg_in = 0; MemSrc_in = 0; call_in = 0; pop_in = 0; ret_in = 0;
      DestReg_in = 0; ALU_addr = 0; NON_ALU_addr = 0; MemWrite_data_in = 0;
   endtask

   // Presents one instruction now (caller is at posedge+1 in IDLE) and runs it to completion.
   // flush_at: 1-based cycle after accept in which flush is raised (0 = never).
   task automatic issue(input logic rw, input logic mr, input logic mw, input logic m2r,
                        input logic msrc, input logic call, input logic pop, input logic ret,
                        input logic [4:0] dest, input logic [31:0] alu, input logic [31:0] nonalu,
                        input logic [31:0] wd, input int ack_dly, input logic [31:0] rdata,
                        input int flush_at);
      wb_exp_t     e;
      logic [31:0] exp_addr;
      valid_in = 1; ALU_done = 1; RegWrite_in = rw; MemRead_in = mr; MemWrite_in = mw;
      MemToReg_in = m2r; MemSrc_in = msrc; call_in = call; pop_in = pop; ret_in = ret;
      DestReg_in = dest; ALU_addr = alu; NON_ALU_addr = nonalu; MemWrite_data_in = wd;
      exp_addr = msrc ? nonalu : alu;
      if (flush_at == 0) begin
         e.rw   = rw && !ret;
         e.dest = dest;
         e.data = (mr || mw) && m2r && !mw ? rdata : alu;
         wb_q.push_back(e);
         wb_pushed++;
         if (ret && (mr || mw)) ret_q.push_back(rdata);
      end
      @(posedge clk); #1;
      clear_ex();
      if (!(mr || mw)) begin
         if (flush_at == 1) flush = 1;
         @(negedge clk);
         chk("pass_req", dmem_req, 0);
         @(posedge clk); #1;
         flush = 0;
      end else begin
         for (int i = 1; i <= ack_dly; i++) begin
            if (i == flush_at) flush = 1;
            @(negedge clk);
            chk("acc_req", dmem_req, 1);
            chk("acc_we", dmem_we, mw);
            chk("acc_addr", dmem_addr, exp_addr);
            chk("acc_stall", stall_out, 1);
            if (mw) chk("acc_wdata", dmem_wdata, wd);
            if (i == ack_dly) begin dmem_ack = 1; dmem_rdata = rdata; end
            @(posedge clk); #1;
            flush = 0; dmem_ack = 0;
         end
      end
   endtask

   initial begin
      rst = 1; flush = 0; dmem_ack = 0; dmem_rdata = 0;
      clear_ex();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", stall_out, 0);
      chk("rst_req", dmem_req, 0);
      chk("rst_we", dmem_we, 0);
      chk("rst_wbv", wb_valid, 0);
      chk("rst_retv", ret_valid, 0);
      chk("rst_wbdata", WB_data, 0);
      chk("rst_addr", dmem_addr, 0);
      chk("rst_err", mem_err, 0);
      @(posedge clk); #1;
      rst = 0;

      // ALU pass-through, then WB pulse with no stall
      issue(1, 0, 0, 0, 0, 0, 0, 0, 5'd5, 32'h1234, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("alu_wbv", wb_valid, 1);
      chk("alu_stall", stall_out, 0);
      chk("alu_req", dmem_req, 0);
      @(posedge clk); #1;
      // load, ack after 3 cycles
      issue(1, 1, 0, 1, 0, 0, 0, 0, 5'd9, 32'h40, 0, 0, 3, 32'hDEADBEEF, 0);
      @(negedge clk);
      chk("load_req_drop", dmem_req, 0);
      @(posedge clk); #1;
      // call: push PC to SP
      issue(0, 0, 1, 0, 1, 1, 0, 0, 5'd0, 32'h11, 32'h3FC, 32'h100, 1, 0, 0);
      // ret: RegWrite requested but forced off
      issue(1, 1, 0, 0, 1, 0, 0, 1, 5'd3, 32'h55, 32'h3FC, 0, 2, 32'h208, 0);
      // pop into r7
      issue(1, 1, 0, 1, 1, 0, 1, 0, 5'd7, 32'h0, 32'h3F8, 0, 2, 32'hCAFE, 0);
      // read and write together: write wins, ALU value written back
      issue(1, 1, 1, 1, 0, 0, 0, 0, 5'd4, 32'h80, 0, 32'h99, 1, 32'h777, 0);
      // back-to-back mix
      issue(1, 0, 0, 0, 0, 0, 0, 0, 5'd1, 32'hA1, 0, 0, 0, 0, 0);
      issue(1, 0, 0, 0, 0, 0, 0, 0, 5'd2, 32'hA2, 0, 0, 0, 0, 0);
      issue(1, 1, 0, 1, 0, 0, 0, 0, 5'd3, 32'hA3, 0, 0, 1, 32'hB3, 0);
      issue(1, 0, 0, 0, 0, 0, 0, 0, 5'd4, 32'hA4, 0, 0, 0, 0, 0);
      // flush mid-ACCESS and in PASS: no writeback expected
      issue(1, 1, 0, 1, 0, 0, 0, 1, 5'd6, 32'h60, 0, 0, 3, 32'h66, 2);
      issue(1, 0, 0, 0, 0, 0, 0, 0, 5'd8, 32'h70, 0, 0, 0, 0, 1);

      // flush in IDLE: nothing captured
      valid_in = 1; ALU_done = 1; MemRead_in = 1; flush = 1; ALU_addr = 32'h90;
      @(posedge clk); #1;
      clear_ex(); flush = 0;
      @(negedge clk);
      chk("idleflush_req", dmem_req, 0);
      @(posedge clk); #1;

      // EX result not final: combinational stall, no capture
      valid_in = 1; ALU_done = 0; MemRead_in = 1; ALU_addr = 32'h94;
      #1 chk("notdone_stall", stall_out, 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("notdone_req", dmem_req, 0);
      @(posedge clk); #1;
      clear_ex();

      // stray ack in IDLE is ignored
      dmem_ack = 1; dmem_rdata = 32'hBAD;
      @(posedge clk); #1;
      dmem_ack = 0;
      @(negedge clk);
      chk("strayack_wbv", wb_valid, 0);
      @(posedge clk); #1;

      // reset in the middle of an access
      valid_in = 1; ALU_done = 1; MemRead_in = 1; MemToReg_in = 1; RegWrite_in = 1; ALU_addr = 32'hC0;
      @(posedge clk); #1;
      clear_ex();
      @(negedge clk);
      chk("rstacc_req_before", dmem_req, 1);
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("rstacc_req_after", dmem_req, 0);
      chk("rstacc_stall", stall_out, 0);
      @(posedge clk); #1;

`ifdef DMEM_TIMEOUT_EN
      valid_in = 1; ALU_done = 1; MemRead_in = 1; ALU_addr = 32'hE0;
      @(posedge clk); #1;
      clear_ex();
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         chk("to_req_held", dmem_req, 1);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("to_req_drop", dmem_req, 0);
      chk("to_err", mem_err, 1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("to_err_sticky", mem_err, 1);
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("to_err_clr", mem_err, 0);
      @(posedge clk); #1;
`else
      // without the watchdog a slow memory is simply waited for
      issue(1, 1, 0, 1, 0, 0, 0, 0, 5'd10, 32'hE0, 0, 0, 10, 32'h1EE7, 0);
      @(negedge clk);
      chk("noto_err", mem_err, 0);
      @(posedge clk); #1;
`endif

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("wb_left", wb_q.size(), 0);
      chk("ret_left", ret_q.size(), 0);
      chk("wb_count", wb_seen, wb_pushed);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
